// File: rtl/wisc_alu_pkg.sv
// Shared WISC ALU definitions: datapath width, opcodes and the issue/response payloads.
package wisc_alu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned OP_W  = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD    = 4'b0000;
  localparam op_t OP_SUB    = 4'b0001;
  localparam op_t OP_XOR    = 4'b0010;
  localparam op_t OP_RED    = 4'b0011;
  localparam op_t OP_SLL    = 4'b0100;
  localparam op_t OP_SRA    = 4'b0101;
  localparam op_t OP_ROR    = 4'b0110;
  localparam op_t OP_PADDSB = 4'b0111;
  localparam op_t OP_LW     = 4'b1000;

  // LW has bit 3 set, so the ALU leaves its flag register alone.
  localparam op_t ALU_IDLE_OP = OP_LW;

  typedef struct packed {
    logic             id;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } issue_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } resp_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester, response and ALU-side signals of the shared ALU controller.
interface alu_share_ctrl_if;
  import wisc_alu_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  op_t              req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  op_t              req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_v;

  op_t              alu_opcode;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_out;
  logic             alu_n;
  logic             alu_z;
  logic             alu_v;

  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_out, alu_n, alu_z, alu_v,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z, rsp_v,
    input  alu_opcode, alu_in1, alu_in2, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_out, alu_n, alu_z, alu_v,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z, rsp_v,
    output alu_opcode, alu_in1, alu_in2, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner only on an accepted transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant_c,
  output logic       o_gid_c
);

  logic r_ptr;

  always_comb begin
    o_gid_c   = (i_valid == 2'b11) ? r_ptr : i_valid[1];
    o_grant_c = 2'b00;
    if (i_valid != 2'b00) begin
      o_grant_c = o_gid_c ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= ~o_gid_c;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one WISC ALU between two requesters through a two-stage issue/response pipeline.
module alu_share_ctrl
  import wisc_alu_pkg::*;
#(
  parameter op_t IDLE_OP = ALU_IDLE_OP
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  logic [1:0] w_req_valid;
  logic [1:0] w_grant;
  logic       w_gid;
  logic       w_adv;
  logic       w_s1_accept;
  logic       w_xfer;
  issue_t     w_new;

  issue_t     r_s1;
  logic       r_s1_valid;
  resp_t      r_s2;
  logic       r_s2_valid;

  assign w_req_valid = {bus.req1_valid, bus.req0_valid};
  // Reset gates both advance and accept so nothing reaches the ALU or the requesters.
  assign w_adv       = rst & r_s1_valid & (~r_s2_valid | bus.rsp_ready);
  assign w_s1_accept = rst & (~r_s1_valid | w_adv);
  assign w_xfer      = w_s1_accept & (|w_req_valid);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_req_valid),
    .i_accept  (w_xfer),
    .o_grant_c (w_grant),
    .o_gid_c   (w_gid)
  );

  always_comb begin
    w_new = '{id: w_gid, op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
    if (w_gid) begin
      w_new = '{id: 1'b1, op: bus.req1_op, a: bus.req1_a, b: bus.req1_b};
    end
  end

  // Issue stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_accept) begin
      r_s1_valid <= |w_req_valid;
      if (w_xfer) begin
        r_s1 <= w_new;
      end
    end
  end

  // Response stage: captures the ALU result on the same edge the ALU flags update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_adv) begin
      r_s2_valid <= 1'b1;
      r_s2       <= '{id: r_s1.id, data: bus.alu_out};
    end else if (bus.rsp_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.req0_ready = w_grant[0] & w_s1_accept;
  assign bus.req1_ready = w_grant[1] & w_s1_accept;

  assign bus.alu_opcode = w_adv ? r_s1.op : IDLE_OP;
  assign bus.alu_in1    = w_adv ? r_s1.a  : '0;
  assign bus.alu_in2    = w_adv ? r_s1.b  : '0;

  assign bus.rsp_valid  = r_s2_valid;
  assign bus.rsp_id     = r_s2.id;
  assign bus.rsp_data   = r_s2.data;
  assign bus.rsp_n      = bus.alu_n;
  assign bus.rsp_z      = bus.alu_z;
  assign bus.rsp_v      = bus.alu_v;
  assign bus.busy       = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU stub, transaction-level reference model, directed and random stimulus.
module tb_alu_share_ctrl;
  import wisc_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_share_ctrl_if bus ();

  alu_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: result and the {n,z,v} flag register after the op.
  function automatic logic [18:0] alu_step(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [2:0] f);
    logic [15:0] r;
    logic [2:0]  nf;
    logic [31:0] aa;
    nf = f;
    aa = {a, a};
    case (op)
      OP_ADD: begin
        r  = a + b;
        nf = {r[15], r == 16'd0, (a[15] == b[15]) && (r[15] != a[15])};
      end
      OP_SUB: begin
        r  = a - b;
        nf = {r[15], r == 16'd0, (a[15] != b[15]) && (r[15] != a[15])};
      end
      OP_XOR: begin r = a ^ b;                              nf[1] = (r == 16'd0); end
      OP_RED:       r = 16'(a[15:8]) + 16'(a[7:0]) + 16'(b[15:8]) + 16'(b[7:0]);
      OP_SLL: begin r = a << b[3:0];                        nf[1] = (r == 16'd0); end
      OP_SRA: begin r = 16'($signed(a) >>> b[3:0]);         nf[1] = (r == 16'd0); end
      OP_ROR: begin r = 16'(aa >> b[3:0]);                  nf[1] = (r == 16'd0); end
      OP_PADDSB: for (int i = 0; i < 4; i++) r[i*4 +: 4] = a[i*4 +: 4] + b[i*4 +: 4];
      default:      r = a + b;
    endcase
    return {r, nf};
  endfunction

  // ALU stub: combinational result, registered flags.
  logic [2:0]  alu_flags = 3'b000;
  logic [18:0] w_step;
  assign w_step = alu_step(bus.alu_opcode, bus.alu_in1, bus.alu_in2, alu_flags);
  assign bus.alu_out = w_step[18:3];
  assign {bus.alu_n, bus.alu_z, bus.alu_v} = alu_flags;
  always @(posedge clk) alu_flags <= w_step[2:0];

  // Reference model: ordered list of accepted ops; op k is visible at max(accept+2, prev consume+1).
  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
    bit          shown;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic        m_ptr     = 1'b0;
  logic [2:0]  m_flags   = 3'b000;
  int          cyc       = 0;
  int          last_cons = -100;
  bit          vis_exp;
  bit          adv_exp;
  int          j;
  logic        g;
  logic [1:0]  rdy_exp;
  logic [18:0] st;

  always @(negedge clk) begin
    cyc++;
    vis_exp = (q.size() > 0) && (cyc >= q[0].acc + 2) && (cyc >= last_cons + 1);
    if (vis_exp && !q[0].shown) begin
      e       = q[0];
      st      = alu_step(e.op, e.a, e.b, m_flags);
      e.data  = st[18:3];
      m_flags = st[2:0];
      e.shown = 1'b1;
      q[0]    = e;
    end
    chk("flags", 32'({bus.rsp_n, bus.rsp_z, bus.rsp_v}), 32'(m_flags));
    if (!rst) begin
      chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("rst_aluop", 32'(bus.alu_opcode), 32'(OP_LW));
      chk("rst_aluin", {bus.alu_in1, bus.alu_in2}, 32'd0);
      q.delete();
      m_ptr     = 1'b0;
      last_cons = -100;
    end else begin
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(vis_exp));
      chk("busy", 32'(bus.busy), 32'(q.size() > 0));
      if (vis_exp) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
      end
      j       = (q.size() > 0 && q[0].shown) ? 1 : 0;
      adv_exp = (j < q.size()) && (j == 0 || bus.rsp_ready);
      if (adv_exp) begin
        chk("alu_op", 32'(bus.alu_opcode), 32'(q[j].op));
        chk("alu_in", {bus.alu_in1, bus.alu_in2}, {q[j].a, q[j].b});
      end else begin
        chk("alu_idle_op", 32'(bus.alu_opcode), 32'(OP_LW));
        chk("alu_idle_in", {bus.alu_in1, bus.alu_in2}, 32'd0);
      end
      g       = (bus.req0_valid && bus.req1_valid) ? m_ptr : bus.req1_valid;
      rdy_exp = 2'b00;
      if ((bus.req0_valid || bus.req1_valid) && (q.size() < 2 || bus.rsp_ready))
        rdy_exp = g ? 2'b10 : 2'b01;
      chk("ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(rdy_exp));
      if (vis_exp && bus.rsp_ready) begin
        void'(q.pop_front());
        last_cons = cyc;
      end
      if (rdy_exp != 2'b00) begin
        e.id    = g;
        e.op    = g ? bus.req1_op : bus.req0_op;
        e.a     = g ? bus.req1_a  : bus.req0_a;
        e.b     = g ? bus.req1_b  : bus.req0_b;
        e.acc   = cyc;
        e.shown = 1'b0;
        e.data  = '0;
        q.push_back(e);
        m_ptr = ~g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Present one op on requester id until accepted; returns at the start of the cycle after acceptance.
  task automatic send(input bit id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit got = 1'b0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
      if (!got) step();
    end
    chk("send_accept", 32'(got), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'd1; bus.req0_b = 16'd1;
    bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 16'd2; bus.req1_b = 16'd2;
    bus.rsp_ready  = 1'b1;

    // Reset held with both requesters valid.
    @(negedge clk);
    chk("lit_rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    @(negedge clk);
    chk("lit_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lit_rst_aluop", 32'(bus.alu_opcode), 32'h8);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("lit_first_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    idle(3);

    // Single op and its fixed latency.
    send(1'b0, OP_ADD, 16'h7FFF, 16'h0001);
    @(negedge clk);
    chk("lit_add_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("lit_add_valid", 32'(bus.rsp_valid), 32'd1);
    chk("lit_add_data", 32'(bus.rsp_data), 32'h8000);
    chk("lit_add_id", 32'(bus.rsp_id), 32'd0);
    chk("lit_add_nzv", 32'({bus.rsp_n, bus.rsp_z, bus.rsp_v}), 32'b101);
    step();
    idle(2);

    // Contention: pointer set to 0 by a req1 op, then alternation.
    send(1'b1, OP_ADD, 16'd1, 16'd2);
    idle(3);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req0_op = OP_SUB; bus.req0_a = 16'($urandom); bus.req0_b = 16'($urandom);
      bus.req1_op = OP_XOR; bus.req1_a = 16'($urandom); bus.req1_b = 16'($urandom);
      @(negedge clk);
      chk("lit_contend_grant", 32'({bus.req1_ready, bus.req0_ready}), (i % 2 == 1) ? 32'b10 : 32'b01);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    idle(4);

    // Backpressure with a stalled SUB in S2 and XOR waiting in S1.
    bus.rsp_ready = 1'b0;
    send(1'b0, OP_SUB, 16'd5, 16'd5);
    send(1'b1, OP_XOR, 16'h00FF, 16'h0F0F);
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 16'd1; bus.req0_b = 16'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_bp_data", 32'(bus.rsp_data), 32'h0000);
      chk("lit_bp_z", 32'(bus.rsp_z), 32'd1);
      chk("lit_bp_aluop", 32'(bus.alu_opcode), 32'h8);
      chk("lit_bp_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("lit_bp_release_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("lit_bp_xor_data", 32'(bus.rsp_data), 32'h0FF0);
    chk("lit_bp_xor_id", 32'(bus.rsp_id), 32'd1);
    step();
    idle(4);

    // PADDSB keeps the zero flag set by the preceding ADD.
    send(1'b0, OP_ADD, 16'h0000, 16'h0000);
    send(1'b0, OP_PADDSB, 16'h1234, 16'h1111);
    @(negedge clk);
    @(negedge clk);
    chk("lit_paddsb_data", 32'(bus.rsp_data), 32'h2345);
    chk("lit_paddsb_nzv", 32'({bus.rsp_n, bus.rsp_z, bus.rsp_v}), 32'b010);
    step();
    idle(3);

    // Reset with both stages full.
    bus.rsp_ready = 1'b0;
    send(1'b1, OP_ADD, 16'd3, 16'd4);
    send(1'b0, OP_SUB, 16'd9, 16'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_mid_busy", 32'(bus.busy), 32'd1);
    chk("lit_mid_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    rst = 1'b1;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lit_post_rst_busy", 32'(bus.busy), 32'd0);
    chk("lit_post_rst_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    idle(3);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 199) != 0);
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_op    = 4'($urandom);
      bus.req0_a     = 16'($urandom);
      bus.req0_b     = ($urandom_range(0, 3) == 0) ? bus.req0_a : 16'($urandom);
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_op    = 4'($urandom);
      bus.req1_a     = 16'($urandom);
      bus.req1_b     = 16'($urandom);
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
